// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences one simulation run of a core under test.
// The core is held in reset, released for a bounded run, and the cause
// of the run ending (halt, timeout, or stall) is recorded.
// Ports:
//   clock, reset         : clock and synchronous active-high reset
//   start                : one-cycle request to begin a run (IDLE/DONE only)
//   halt                 : core retired a halt instruction (RUN only)
//   pc_valid, pc         : retiring program counter (RUN only)
//   core_reset           : reset to the core, low only while running
//   running, done        : high exactly in RUN / DONE
//   status               : end cause 00 none, 01 halt, 10 timeout, 11 stall
//   cycle_count          : RUN cycles elapsed (saturating)
//   retire_count         : pc_valid cycles seen in RUN (saturating)
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 3000,
    parameter int unsigned STALL_LIMIT  = 64,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 pc_valid,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CYCLE_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_STALL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [STALL_W-1:0]    stall_cnt;
    logic [PC_WIDTH-1:0]   last_pc;
    logic                  last_pc_valid;

    logic                  progress_c;
    logic                  exit_c;
    logic [1:0]            cause_c;
    logic [CNT_WIDTH-1:0]  cycle_next_c;
    logic [CNT_WIDTH-1:0]  retire_next_c;

    // RUN-cycle evaluation: progress, saturating increments, exit priority
    always_comb begin
        progress_c    = 1'b0;
        exit_c        = 1'b0;
        cause_c       = ST_NONE;
        cycle_next_c  = cycle_count;
        retire_next_c = retire_count;

        progress_c = pc_valid && (!last_pc_valid || (pc != last_pc));

        if (cycle_count != CNT_MAX) begin
            cycle_next_c = cycle_count + CNT_WIDTH'(1);
        end
        if (pc_valid && (retire_count != CNT_MAX)) begin
            retire_next_c = retire_count + CNT_WIDTH'(1);
        end

        if (halt) begin
            exit_c  = 1'b1;
            cause_c = ST_HALT;
        end else if (cycle_count == CYCLE_LAST) begin
            exit_c  = 1'b1;
            cause_c = ST_TIMEOUT;
        end else if ((stall_cnt == STALL_LAST) && !progress_c) begin
            exit_c  = 1'b1;
            cause_c = ST_STALL;
        end
    end

    // Run sequencer with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            stall_cnt     <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
            core_reset    <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            status        <= ST_NONE;
            cycle_count   <= '0;
            retire_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A new run clears the previous result on the start edge
                    if (start) begin
                        state        <= RESET_HOLD;
                        hold_cnt     <= '0;
                        done         <= 1'b0;
                        status       <= ST_NONE;
                        cycle_count  <= '0;
                        retire_count <= '0;
                    end
                end

                RESET_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state         <= RUN;
                        running       <= 1'b1;
                        core_reset    <= 1'b0;
                        stall_cnt     <= '0;
                        last_pc_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                RUN: begin
                    // The exiting cycle is still counted
                    cycle_count  <= cycle_next_c;
                    retire_count <= retire_next_c;
                    if (pc_valid) begin
                        last_pc       <= pc;
                        last_pc_valid <= 1'b1;
                    end
                    if (progress_c) begin
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                    if (exit_c) begin
                        state      <= DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        core_reset <= 1'b1;
                        status     <= cause_c;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed and randomized checks of sim_run_ctrl against a
// per-run reference model (end cycle, end cause, retire count).
module tb_sim_run_ctrl;

    localparam int unsigned RC = 3;
    localparam int unsigned MC = 20;
    localparam int unsigned SL = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          pc_valid = 1'b0;
    logic [PW-1:0] pc = '0;
    logic          core_reset;
    logic          running;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] retire_count;

    int total = 0;
    int fails = 0;

    bit            v_halt  [1:MC];
    bit            v_valid [1:MC];
    logic [PW-1:0] v_pc    [1:MC];

    sim_run_ctrl #(
        .RESET_CYCLES(RC),
        .MAX_CYCLES  (MC),
        .STALL_LIMIT (SL),
        .PC_WIDTH    (PW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .pc_valid    (pc_valid),
        .pc          (pc),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .status      (status),
        .cycle_count (cycle_count),
        .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: walk the run cycle by cycle using the end-of-run rules
    function automatic void model(output int end_k, output int st, output int ret);
        int            noprog;
        bit            have;
        logic [PW-1:0] lastp;
        bit            prog;
        noprog = 0;
        have   = 0;
        lastp  = '0;
        ret    = 0;
        end_k  = MC;
        st     = 2;
        for (int k = 1; k <= int'(MC); k++) begin
            if (v_valid[k]) ret++;
            prog = v_valid[k] && (!have || v_pc[k] != lastp);
            if (v_valid[k]) begin
                have  = 1;
                lastp = v_pc[k];
            end
            noprog = prog ? 0 : noprog + 1;
            if (v_halt[k]) begin
                end_k = k; st = 1; return;
            end else if (k == int'(MC)) begin
                end_k = k; st = 2; return;
            end else if (noprog == int'(SL)) begin
                end_k = k; st = 3; return;
            end
        end
    endfunction

    // Start a run from IDLE or DONE and check it cycle by cycle
    task automatic run_and_check(input string name, input int exp_end, input int exp_st,
                                 input int exp_ret, input int abort_at, input bit rnd_start);
        int ret_so_far;
        ret_so_far = 0;
        start    = 1'b1;
        halt     = 1'($urandom_range(0, 1));
        pc_valid = 1'($urandom_range(0, 1));
        pc       = PW'($urandom);
        step();
        start = 1'b0;
        for (int i = 0; i < int'(RC); i++) begin
            total++;
            if ({core_reset, running, done, status, cycle_count, retire_count} !==
                {1'b1, 1'b0, 1'b0, 2'b00, CW'(0), CW'(0)}) begin
                fails++;
                $display("FAIL %s hold%0d: cr=%0b run=%0b done=%0b st=%0d cyc=%0d ret=%0d, want cr=1 run=0 done=0 st=0 cyc=0 ret=0",
                         name, i, core_reset, running, done, status, cycle_count, retire_count);
            end
            halt     = 1'($urandom_range(0, 1));
            pc_valid = 1'($urandom_range(0, 1));
            pc       = PW'($urandom);
            step();
        end
        total++;
        if ({core_reset, running, done} !== 3'b010) begin
            fails++;
            $display("FAIL %s run_entry: cr/run/done=%b, want 010", name, {core_reset, running, done});
        end
        for (int k = 1; k <= int'(MC); k++) begin
            halt     = v_halt[k];
            pc_valid = v_valid[k];
            pc       = v_pc[k];
            start    = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
                step();
                reset = 1'b0; start = 1'b0; halt = 1'b0; pc_valid = 1'b0;
                total++;
                if ({core_reset, running, done, status, cycle_count, retire_count} !==
                    {1'b1, 1'b0, 1'b0, 2'b00, CW'(0), CW'(0)}) begin
                    fails++;
                    $display("FAIL %s abort: cr=%0b run=%0b done=%0b st=%0d cyc=%0d ret=%0d, want 1 0 0 0 0 0",
                             name, core_reset, running, done, status, cycle_count, retire_count);
                end
                step();
                total++;
                if ({core_reset, running, done, status} !== 5'b10000) begin
                    fails++;
                    $display("FAIL %s abort_idle: cr/run/done/st=%b, want 10000", name,
                             {core_reset, running, done, status});
                end
                return;
            end
            step();
            if (v_valid[k]) ret_so_far++;
            if (k == exp_end) begin
                start = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    total++;
                    if ({core_reset, running, done, status, cycle_count, retire_count} !==
                        {1'b1, 1'b0, 1'b1, 2'(exp_st), CW'(exp_end), CW'(exp_ret)}) begin
                        fails++;
                        $display("FAIL %s done%0d: cr=%0b run=%0b done=%0b st=%0d cyc=%0d ret=%0d, want 1 0 1 %0d %0d %0d",
                                 name, h, core_reset, running, done, status, cycle_count, retire_count,
                                 exp_st, exp_end, exp_ret);
                    end
                    halt     = 1'($urandom_range(0, 1));
                    pc_valid = 1'($urandom_range(0, 1));
                    pc       = PW'($urandom);
                    step();
                end
                halt = 1'b0; pc_valid = 1'b0;
                return;
            end
            total++;
            if ({core_reset, running, done, status, cycle_count, retire_count} !==
                {1'b0, 1'b1, 1'b0, 2'b00, CW'(k), CW'(ret_so_far)}) begin
                fails++;
                $display("FAIL %s cyc%0d: cr=%0b run=%0b done=%0b st=%0d cyc=%0d ret=%0d, want 0 1 0 0 %0d %0d",
                         name, k, core_reset, running, done, status, cycle_count, retire_count, k, ret_so_far);
            end
        end
        total++;
        fails++;
        $display("FAIL %s no_exit: run did not end by cycle %0d", name, MC);
    endtask

    function automatic void fill_linear(input int halt_at);
        for (int k = 1; k <= int'(MC); k++) begin
            v_halt[k]  = (k == halt_at);
            v_valid[k] = 1'b1;
            v_pc[k]    = PW'(4 * (k - 1));
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        reset = 1'b0;
        start = 1'b0;
        total++;
        if ({core_reset, running, done, status, cycle_count, retire_count} !==
            {1'b1, 1'b0, 1'b0, 2'b00, CW'(0), CW'(0)}) begin
            fails++;
            $display("FAIL reset: cr=%0b run=%0b done=%0b st=%0d cyc=%0d ret=%0d, want 1 0 0 0 0 0",
                     core_reset, running, done, status, cycle_count, retire_count);
        end
        step();
        total++;
        if ({core_reset, running, done} !== 3'b100) begin
            fails++;
            $display("FAIL reset_idle: cr/run/done=%b, want 100", {core_reset, running, done});
        end
    endtask

    task automatic test_halt();
        fill_linear(6);
        run_and_check("halt", 6, 1, 6, 0, 1'b0);
    endtask

    task automatic test_restart_done();
        fill_linear(4);
        run_and_check("restart", 4, 1, 4, 0, 1'b1);
    endtask

    task automatic test_timeout();
        fill_linear(0);
        run_and_check("timeout", 20, 2, 20, 0, 1'b1);
    endtask

    task automatic test_stall();
        for (int k = 1; k <= int'(MC); k++) begin
            v_halt[k]  = 1'b0;
            v_valid[k] = 1'b1;
            v_pc[k]    = (k == 1) ? PW'(16'h38) : PW'(16'h40);
        end
        run_and_check("stall", 6, 3, 6, 0, 1'b0);
    endtask

    task automatic test_halt_timeout();
        fill_linear(20);
        run_and_check("halt_timeout", 20, 1, 20, 0, 1'b0);
    endtask

    task automatic test_reset_abort();
        fill_linear(0);
        run_and_check("abort", 99, 0, 0, 5, 1'b0);
        fill_linear(3);
        run_and_check("after_abort", 3, 1, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        int e, s, r;
        for (int n = 0; n < 25; n++) begin
            for (int k = 1; k <= int'(MC); k++) begin
                v_halt[k]  = ($urandom_range(0, 24) == 0);
                v_valid[k] = ($urandom_range(0, 3) != 0);
                v_pc[k]    = PW'(4 * $urandom_range(0, 1));
            end
            model(e, s, r);
            run_and_check($sformatf("rand%0d", n), e, s, r, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_restart_done();
        test_timeout();
        test_stall();
        test_halt_timeout();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
